// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core front end.
// Matrices are 4x4 bytes, so operand sets are whole multiples of 16 registers.
package tensor_core_pkg;

  localparam int unsigned MATRIX_DIM                  = 4;
  localparam int unsigned MATRIX_ELEMENTS             = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned DEFAULT_NUMBER_OF_REGISTERS = 32;

  typedef enum logic [1:0] {
    LOAD,
    FLUSH,
    READY,
    COMPUTE
  } loader_state_t;

  // Keep the address width at least one bit, even for degenerate sizes.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_core_matrix_loader_if.sv
// Stream, register-file write and compute handshake bundle of the matrix loader.
// The master modport is the loader side; slave is the host/tensor-core side.
interface tensor_core_matrix_loader_if
  import tensor_core_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int unsigned COUNT_WIDTH         = 8
);
  localparam int unsigned AddrWidth = addr_width(NUMBER_OF_REGISTERS);

  logic [7:0]             stream_data_in;
  logic                   stream_valid_in;
  logic                   stream_ready_out;
  logic                   write_enable_out;
  logic [AddrWidth-1:0]   write_register_address_out;
  logic [7:0]             write_data_out;
  logic                   compute_valid_out;
  logic                   compute_ready_in;
  logic                   compute_done_in;
  logic [COUNT_WIDTH-1:0] load_count_out;
  logic                   busy_out;

  modport master (
    input  stream_data_in,
    input  stream_valid_in,
    output stream_ready_out,
    output write_enable_out,
    output write_register_address_out,
    output write_data_out,
    output compute_valid_out,
    input  compute_ready_in,
    input  compute_done_in,
    output load_count_out,
    output busy_out
  );

  modport slave (
    output stream_data_in,
    output stream_valid_in,
    input  stream_ready_out,
    input  write_enable_out,
    input  write_register_address_out,
    input  write_data_out,
    input  compute_valid_out,
    output compute_ready_in,
    output compute_done_in,
    input  load_count_out,
    input  busy_out
  );

endinterface

// File: rtl/tensor_core_matrix_loader.sv
// Streams operand bytes into the tensor core register file and hands each full set to the core,
// back-pressuring the stream until the core reports it is done with the set.
module tensor_core_matrix_loader
  import tensor_core_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int unsigned COUNT_WIDTH         = 8
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  tensor_core_matrix_loader_if.master bus
);

  localparam int unsigned          AddrWidth = addr_width(NUMBER_OF_REGISTERS);
  localparam logic [AddrWidth-1:0] LastIndex = AddrWidth'(NUMBER_OF_REGISTERS - 1);

  if (((NUMBER_OF_REGISTERS % MATRIX_ELEMENTS) != 0) ||
      (NUMBER_OF_REGISTERS < MATRIX_ELEMENTS)) begin : g_bad_size
    $error("NUMBER_OF_REGISTERS must be a non-zero multiple of 16");
  end

  loader_state_t          state_q, state_d;
  logic [AddrWidth-1:0]   idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   write_enable_q;
  logic [AddrWidth-1:0]   write_address_q;
  logic [7:0]             write_data_q;
  logic                   stream_ready;
  logic                   compute_valid;
  logic                   accept;

  assign accept = bus.stream_valid_in & stream_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    stream_ready  = 1'b0;
    compute_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        stream_ready = 1'b1;
        if (bus.stream_valid_in) begin
          if (idx_q == LastIndex) begin
            idx_d   = '0;
            state_d = FLUSH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // The last byte's write strobe is visible in this cycle; valid follows it.
      FLUSH: state_d = READY;
      READY: begin
        compute_valid = 1'b1;
        if (bus.compute_ready_in) state_d = COMPUTE;
      end
      // compute_done_in is only honoured here, so a done on the handshake cycle is dropped.
      COMPUTE: begin
        if (bus.compute_done_in) begin
          state_d = LOAD;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q         <= LOAD;
      idx_q           <= '0;
      count_q         <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      count_q        <= count_d;
      write_enable_q <= accept;
      if (accept) begin
        write_address_q <= idx_q;
        write_data_q    <= bus.stream_data_in;
      end
    end
  end

  assign bus.stream_ready_out           = stream_ready;
  assign bus.write_enable_out           = write_enable_q;
  assign bus.write_register_address_out = write_address_q;
  assign bus.write_data_out             = write_data_q;
  assign bus.compute_valid_out          = compute_valid;
  assign bus.load_count_out             = count_q;
  assign bus.busy_out                   = (state_q != LOAD) || (idx_q != '0);

endmodule
